// File: rtl/window_line_buffer.sv
// Purpose: buffers KERNEL_SIZE-1 image lines and presents a KxK sliding window over a raster pixel stream.
// Latency: 1 cycle from pixel accept to window_out[K-1][K-1]; frame_done one cycle after the last pixel.
// Backpressure: none; pixel_valid gaps of any length freeze all state; optional WINDOW_EDGE_MASK_EN zero-pads edges.
module window_line_buffer #(
    parameter int KERNEL_SIZE = 3,
    parameter int WORD_SIZE   = 8,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic signed [WORD_SIZE-1:0]   pixel_in,
    input  logic                          pixel_valid,
    input  logic                          frame_start,
    output logic signed [WORD_SIZE-1:0]   window_out [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0],
    output logic                          window_valid,
    output logic [$clog2(IMG_HEIGHT)-1:0] row_out,
    output logic [$clog2(IMG_WIDTH)-1:0]  col_out,
    output logic                          frame_done
);

    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int CW = $clog2(IMG_WIDTH);

    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);

    localparam logic [0:0] WAIT_SOF = 1'b0;
    localparam logic [0:0] STREAM   = 1'b1;

    logic [0:0]    state;
    // Position the next accepted pixel will take, unless frame_start restarts it.
    logic [RW-1:0] row_cnt;
    logic [CW-1:0] col_cnt;

    logic          accept;
    logic          last_px;
    logic          valid_cond;
    logic [RW-1:0] cur_row;
    logic [CW-1:0] cur_col;

    // Line buffers addressed by column: entry [b][c] holds the pixel from row (r-1-b) at column c,
    // which is exactly what a chain of IMG_WIDTH-deep FIFOs would deliver at that column.
    logic signed [WORD_SIZE-1:0] line_buf [KERNEL_SIZE-1][IMG_WIDTH];

    logic signed [WORD_SIZE-1:0] new_col  [KERNEL_SIZE-1:0];
    logic signed [WORD_SIZE-1:0] win_next [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0];

    // Accept decision and coordinates of the pixel being accepted this cycle.
    always_comb begin
        accept  = pixel_valid && (frame_start || (state == STREAM));
        cur_row = frame_start ? '0 : row_cnt;
        cur_col = frame_start ? '0 : col_cnt;
        last_px = (cur_row == LAST_ROW) && (cur_col == LAST_COL);
`ifdef WINDOW_EDGE_MASK_EN
        valid_cond = 1'b1;
`else
        valid_cond = (cur_row >= RW'(KERNEL_SIZE - 1)) && (cur_col >= CW'(KERNEL_SIZE - 1));
`endif
    end

    // Build the incoming window column (oldest line at index 0) and the left-shifted window.
    always_comb begin
        new_col[KERNEL_SIZE-1] = pixel_in;
        for (int b = 0; b < KERNEL_SIZE - 1; b++) begin
            new_col[KERNEL_SIZE-2-b] = line_buf[b][cur_col];
        end
        for (int i = 0; i < KERNEL_SIZE; i++) begin
            for (int j = 0; j < KERNEL_SIZE - 1; j++) begin
                win_next[i][j] = window_out[i][j+1];
            end
            win_next[i][KERNEL_SIZE-1] = new_col[i];
        end
`ifdef WINDOW_EDGE_MASK_EN
        // Elements whose source lies above row 0 or left of column 0 are zero padding.
        for (int i = 0; i < KERNEL_SIZE; i++) begin
            for (int j = 0; j < KERNEL_SIZE; j++) begin
                if ((int'(cur_row) < KERNEL_SIZE - 1 - i) || (int'(cur_col) < KERNEL_SIZE - 1 - j)) begin
                    win_next[i][j] = '0;
                end
            end
        end
`endif
    end

    // Push the accepted pixel into line 0 and cascade each line's old entry one line down.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_buf[0][cur_col] <= pixel_in;
            for (int b = 1; b < KERNEL_SIZE - 1; b++) begin
                line_buf[b][cur_col] <= line_buf[b-1][cur_col];
            end
        end
    end

    // Frame FSM, position counters and registered window outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= WAIT_SOF;
            row_cnt      <= '0;
            col_cnt      <= '0;
            row_out      <= '0;
            col_out      <= '0;
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
            for (int i = 0; i < KERNEL_SIZE; i++) begin
                for (int j = 0; j < KERNEL_SIZE; j++) begin
                    window_out[i][j] <= '0;
                end
            end
        end else begin
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
            if (accept) begin
                window_out   <= win_next;
                row_out      <= cur_row;
                col_out      <= cur_col;
                window_valid <= valid_cond;
                if (last_px) begin
                    state      <= WAIT_SOF;
                    row_cnt    <= '0;
                    col_cnt    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    state <= STREAM;
                    if (cur_col == LAST_COL) begin
                        col_cnt <= '0;
                        row_cnt <= cur_row + 1'b1;
                    end else begin
                        col_cnt <= cur_col + 1'b1;
                        row_cnt <= cur_row;
                    end
                end
            end
        end
    end

endmodule

// File: doc/window_line_buffer.md
Name: window_line_buffer

Overview:
- Upstream feeder for the kernel convolution stage.
- Accepts a raster-order pixel stream, one signed WORD_SIZE word per valid cycle, and buffers KERNEL_SIZE-1 full image lines.
- Presents a registered KERNEL_SIZE x KERNEL_SIZE window whose bottom-right element is the most recently accepted pixel.
- Array shape and element type match the convolution stage's buffer_in.

Parameters:
KERNEL_SIZE, 3, window height and width in pixels (>=2)
WORD_SIZE, 8, bits per signed pixel word
IMG_WIDTH, 640, pixels per line
IMG_HEIGHT, 480, lines per frame

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
pixel_in  in  signed [WORD_SIZE-1:0]  input pixel
pixel_valid  in  1  pixel_in accepted this cycle when high
frame_start  in  1  qualified by pixel_valid; marks pixel (0,0) of a frame
window_out  out  signed [WORD_SIZE-1:0] [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0]  window; [r][c], r=0 oldest line, c=0 oldest column
window_valid  out  1  one-cycle pulse per valid window
row_out  out  $clog2(IMG_HEIGHT)  row of window_out[K-1][K-1]
col_out  out  $clog2(IMG_WIDTH)  column of window_out[K-1][K-1]
frame_done  out  1  one-cycle pulse after last pixel of a frame is accepted

Behaviour:
- Reset: window_out all 0, window_valid=0, row_out=0, col_out=0, frame_done=0, counters=0, FSM in WAIT_SOF. Line-buffer contents are don't-care.
- FSM has two states, WAIT_SOF and STREAM.
  - WAIT_SOF: pixels without frame_start are dropped, with no state change. pixel_valid&frame_start accepts the pixel as (0,0) and moves to STREAM.
  - STREAM: each accepted pixel advances col. At col=IMG_WIDTH-1, col wraps to 0 and row increments.
  - Accepting (IMG_HEIGHT-1, IMG_WIDTH-1) pulses frame_done on the next cycle and returns to WAIT_SOF.
- pixel_valid low: nothing shifts; all outputs except pulses hold. Gaps of any length are legal.
- Latency is 1 cycle: the pixel accepted at edge N appears at window_out[K-1][K-1] after edge N, together with its row_out/col_out.
- Window contents after accepting pixel (r,c): window_out[i][j] = pixel(r-(K-1-i), c-(K-1-j)).
- Line buffers: K-1 buffers, each IMG_WIDTH deep, chained. Each accepted pixel pushes into buffer 0, and each buffer's oldest entry pushes into the next. Window columns shift left by one on each accept.
- window_valid=1 only when the accepted pixel has r>=K-1 and c>=K-1, giving (IMG_WIDTH-K+1)*(IMG_HEIGHT-K+1) pulses per frame.
  - Windows that straddle a line wrap (c<K-1) are never flagged valid.
- frame_start with pixel_valid while in STREAM: the current frame is abandoned without frame_done. The pixel becomes (0,0) of the new frame and counters restart. Stale buffer data is never flagged valid, by the r/c rule above.
- Reset mid-frame returns to the reset state in the same cycle and drops the partial frame.
- Pixel words pass through unmodified; there is no arithmetic on pixel data.
- Counter widths are $clog2 of the dimension. A dimension equal to 1 is unsupported.

Optional Feature:
- Macro: WINDOW_EDGE_MASK_EN.
- Defined:
  - window_valid pulses for every accepted pixel in STREAM (IMG_WIDTH*IMG_HEIGHT per frame).
  - Any window element whose source row or column is <0 is forced to 0 in window_out.
  - Masking is registered with the window; latency is unchanged.
- Undefined: behaviour exactly as in Behaviour, with raw buffer contents and no masking logic.

Test Plan:
All cases use K=3, WORD_SIZE=8, W=8, H=6, pixel value = row*8+col, unless stated.
1. Reset 2 cycles, then stream a full frame with no gaps -> after accepting (2,2): window_valid=1, window_out[0][0]=0, [0][2]=2, [1][1]=9, [2][2]=18, row_out=2, col_out=2. 24 window_valid pulses total. One frame_done, one cycle after pixel (5,7).
2. Same frame with pixel_valid low on every other cycle -> window values and pulse count identical to case 1; outputs hold during gaps.
3. 10 pixels without frame_start, then a normal frame -> first 10 pixels ignored; results identical to case 1.
4. Assert frame_start again at pixel (3,4), then stream a full frame -> no frame_done for the aborted frame. New frame gives exactly 24 pulses, first at its (2,2) with [2][2]=18.
5. reset high for 1 cycle at pixel (4,0), then a full frame -> all outputs 0 the cycle after reset; next frame matches case 1.
6. With WINDOW_EDGE_MASK_EN defined, pixel (0,1) -> window_valid=1, [2][1]=0 (pixel 0), [2][2]=1, all other elements 0. 48 pulses per frame.
